// File: rtl/serial_addsub_if.sv
// Request/result bundle of the bit-serial adder/subtractor.
// The requester drives the operands; the datapath returns result flags and status.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b,
        input  sum, carry_out, overflow, zero, busy, done
    );

    modport slave (
        input  start, op, a, b,
        output sum, carry_out, overflow, zero, busy, done
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one full-add step per clock, LSB first.
// Subtraction is a + ~b + 1, with the +1 entering as the initial carry.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_addsub_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] sum_r;
    logic             carry_out_r;
    logic             overflow_r;
    logic             zero_r;
    logic             busy_r;
    logic             done_r;

    // Full-add step for the current bit, built from two half-add steps.
    logic             ha1_s, ha1_c, ha2_s, ha2_c;
    logic             bit_s, bit_c;
    logic [WIDTH-1:0] acc_next;
    logic             last_bit;

    assign ha1_s    = a_sh[0] ^ b_sh[0];
    assign ha1_c    = a_sh[0] & b_sh[0];
    assign ha2_s    = ha1_s ^ carry;
    assign ha2_c    = ha1_s & carry;
    assign bit_s    = ha2_s;
    assign bit_c    = ha1_c | ha2_c;
    assign acc_next = {bit_s, acc[WIDTH-1:1]};
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            carry       <= 1'b0;
            sum_r       <= '0;
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
            zero_r      <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // NOTE: operand shifters and accumulator are left unreset; they are always loaded here before use.
                        a_sh   <= bus.a;
                        b_sh   <= bus.b ^ {WIDTH{bus.op}};
                        acc    <= '0;
                        carry  <= bus.op;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    acc   <= acc_next;
                    carry <= bit_c;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        // Here carry is the carry into the MSB and bit_c the carry out of it.
                        sum_r       <= acc_next;
                        carry_out_r <= bit_c;
                        overflow_r  <= carry ^ bit_c;
                        zero_r      <= (acc_next == '0);
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.sum       = sum_r;
    assign bus.carry_out = carry_out_r;
    assign bus.overflow  = overflow_r;
    assign bus.zero      = zero_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

    a_busy_done_excl: assert property (@(posedge clk) !(busy_r && done_r));
    a_done_single:    assert property (@(posedge clk) disable iff (rst) done_r |=> !done_r);
endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..32).
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, the reset, synchronous and active-high.
REQ-004 The module SHALL have port start, input, 1, the operation request, sampled only in IDLE.
REQ-005 The module SHALL have port op, input, 1, the operation select: 0 = a+b, 1 = a-b; sampled with start.
REQ-006 The module SHALL have port a, input, WIDTH, the first operand, sampled with start.
REQ-007 The module SHALL have port b, input, WIDTH, the second operand, sampled with start.
REQ-008 The module SHALL have port sum, output, WIDTH, the registered result of the last completed operation.
REQ-009 The module SHALL have port carry_out, output, 1, the final carry of the last operation (sub: 1 = no borrow, a>=b unsigned).
REQ-010 The module SHALL have port overflow, output, 1, the two's-complement signed overflow of the last operation.
REQ-011 The module SHALL have port zero, output, 1, asserted when sum == 0.
REQ-012 The module SHALL have port busy, output, 1, high while bits are being processed.
REQ-013 The module SHALL have port done, output, 1, a single-cycle completion pulse.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 In IDLE with start=1, the next edge SHALL latch a, b XOR {WIDTH{op}}, and op; set carry register = op; clear bit counter to 0; and enter RUN.
REQ-016 In RUN, each edge SHALL process exactly one bit i (LSB first) as one full-add step built from two half-add steps: s_i = a_i ^ b'_i ^ c and c' = (a_i & b'_i) | (c & (a_i ^ b'_i)).
REQ-017 The bit counter SHALL increment each RUN edge; the edge processing bit WIDTH-1 SHALL enter DONE.
REQ-018 sum, carry_out, overflow and zero SHALL update only on the RUN->DONE edge, never with partial values.
REQ-019 overflow SHALL equal (carry into MSB) XOR (carry out of MSB).
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-021 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-022 Latency: start sampled at edge k SHALL give busy=1 for cycles k+1..k+WIDTH and done=1 in cycle k+WIDTH+1.
REQ-023 start asserted in RUN or DONE SHALL be ignored (not queued); start held high SHALL begin a new operation on the first edge back in IDLE.
REQ-024 Changes to a, b, op after the sampling edge SHALL not affect the operation in progress.
REQ-025 sum, carry_out, overflow and zero SHALL hold their values from operation completion until the next RUN->DONE edge.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, clear the counter and carry register, and drive sum=0, carry_out=0, overflow=0, busy=0, done=0, zero=1, overriding start.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation without any done pulse and without updating the result outputs.

Verification
REQ-028 With WIDTH=8, add 0x0F+0x01 SHALL give sum=0x10, carry_out=0, overflow=0, zero=0, with done exactly 9 cycles after the start edge.
REQ-029 Add 0xFF+0x01 SHALL give sum=0x00, carry_out=1, zero=1, overflow=0; add 0x7F+0x01 SHALL give sum=0x80, overflow=1, carry_out=0.
REQ-030 Sub 0x05-0x07 SHALL give sum=0xFE, carry_out=0; sub 0x80-0x01 SHALL give sum=0x7F, carry_out=1, overflow=1.
REQ-031 start pulsed with different operands at cycle 3 of RUN SHALL be ignored, and the original result SHALL be reported.
REQ-032 rst asserted at RUN cycle 4 SHALL give no done pulse, outputs at reset values, and a correct result for the next start.
REQ-033 start held high continuously SHALL produce back-to-back operations with a period of WIDTH+2 cycles and one done pulse each.
